// File: rtl/cpu_clk_pkg.sv
// Shared types for the CPU clock sequencer: FSM states and the SW/speed input encodings.
package cpu_clk_pkg;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_STEP_IDLE,
    ST_STEP_HI,
    ST_STEP_LO,
    ST_HALTED
  } state_t;

  typedef enum logic {
    MODE_RUN  = 1'b0,
    MODE_STEP = 1'b1
  } mode_t;

  typedef enum logic {
    SPEED_FAST = 1'b0,
    SPEED_SLOW = 1'b1
  } speed_t;

endpackage

// File: rtl/cpu_clk_ctrl_if.sv
// Control inputs and CPU clock outputs of the clock sequencer, bundled for the top-level port.
interface cpu_clk_ctrl_if #(
  parameter int unsigned CYC_W = 32
);
  logic             SW;
  logic             speed;
  logic             step_btn;
  logic             halt;
  logic             CPUCLK;
  logic             cpu_ce;
  logic             running;
  logic [CYC_W-1:0] cycle_cnt;

  modport master (
    output SW, speed, step_btn, halt,
    input  CPUCLK, cpu_ce, running, cycle_cnt
  );

  modport slave (
    input  SW, speed, step_btn, halt,
    output CPUCLK, cpu_ce, running, cycle_cnt
  );
endinterface

// File: rtl/cpu_clk_ctrl_btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, level debounce over DB_CNT stable cycles,
// and a one-clock pulse on each accepted press.
module btn_debounce #(
  parameter int unsigned DB_CNT = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);
  localparam int unsigned CW = (DB_CNT < 2) ? 1 : $clog2(DB_CNT);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CNT - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // accepting a mismatch always flips the level, so sync2 is the new level
        level <= sync2;
        cnt   <= '0;
        press <= sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/cpu_clk_ctrl.sv
// CPU clock sequencer: free-running divided clock (RUN) or one CPU cycle per debounced
// button press (STEP), with CPU-requested halt; also a clk-domain enable and cycle counter.
module cpu_clk_ctrl
  import cpu_clk_pkg::*;
#(
  parameter int unsigned DIV_W    = 26,
  parameter int unsigned DIV_FAST = 2,
  parameter int unsigned DIV_SLOW = 25_000_000,
  parameter int unsigned DB_CNT   = 1_000_000,
  parameter int unsigned CYC_W    = 32
) (
  input  logic           clk,
  input  logic           rst,
  cpu_clk_ctrl_if.slave  bus
);
  localparam logic [DIV_W-1:0] FAST_LAST = DIV_W'(DIV_FAST - 1);
  localparam logic [DIV_W-1:0] SLOW_LAST = DIV_W'(DIV_SLOW - 1);

  state_t           state;
  logic [DIV_W-1:0] hcnt;
  logic [DIV_W-1:0] h_last;
  logic             tick;
  logic             step_req;
  logic             clk_q;
  logic             ce_q;
  logic             run_q;
  logic [CYC_W-1:0] cnt_q;

  btn_debounce #(
    .DB_CNT (DB_CNT)
  ) u_btn (
    .clk   (clk),
    .rst   (rst),
    .btn   (bus.step_btn),
    .press (step_req)
  );

  // ">=" rather than "==" so a mid-phase drop to the fast speed ticks on the next clk
  assign h_last = (bus.speed == SPEED_SLOW) ? SLOW_LAST : FAST_LAST;
  assign tick   = (hcnt >= h_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_STEP_IDLE;
      hcnt  <= '0;
      clk_q <= 1'b0;
      ce_q  <= 1'b0;
      run_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      ce_q <= 1'b0;
      case (state)
        ST_RUN: begin
          if (!tick) begin
            hcnt <= hcnt + DIV_W'(1);
          end else begin
            hcnt <= '0;
            if (clk_q) begin
              clk_q <= 1'b0;
            end else if (bus.halt) begin
              state <= ST_HALTED;
              run_q <= 1'b0;
            end else if (bus.SW == MODE_STEP) begin
              state <= ST_STEP_IDLE;
              run_q <= 1'b0;
            end else begin
              clk_q <= 1'b1;
              ce_q  <= 1'b1;
              cnt_q <= cnt_q + CYC_W'(1);
            end
          end
        end

        ST_STEP_IDLE: begin
          clk_q <= 1'b0;
          if (bus.halt) begin
            state <= ST_HALTED;
          end else if (bus.SW == MODE_RUN) begin
            state <= ST_RUN;
            run_q <= 1'b1;
            hcnt  <= '0;
          end else if (step_req) begin
            state <= ST_STEP_HI;
            clk_q <= 1'b1;
            ce_q  <= 1'b1;
            cnt_q <= cnt_q + CYC_W'(1);
            hcnt  <= '0;
          end
        end

        ST_STEP_HI: begin
          if (tick) begin
            state <= ST_STEP_LO;
            clk_q <= 1'b0;
            hcnt  <= '0;
          end else begin
            hcnt <= hcnt + DIV_W'(1);
          end
        end

        ST_STEP_LO: begin
          if (tick) begin
            state <= ST_STEP_IDLE;
            hcnt  <= '0;
          end else begin
            hcnt <= hcnt + DIV_W'(1);
          end
        end

        ST_HALTED: begin
          clk_q <= 1'b0;
        end

        default: begin
          state <= ST_STEP_IDLE;
          clk_q <= 1'b0;
          run_q <= 1'b0;
          hcnt  <= '0;
        end
      endcase
    end
  end

  assign bus.CPUCLK    = clk_q;
  assign bus.cpu_ce    = ce_q;
  assign bus.running   = run_q;
  assign bus.cycle_cnt = cnt_q;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Bench for cpu_clk_ctrl: randomized timing of speed/SW/button/halt, checked against phase-length,
// press-acceptance and cycle-count rules derived from the clocking behaviour.
module tb_cpu_clk_ctrl;
  localparam int unsigned DIV_FAST = 2;
  localparam int unsigned DIV_SLOW = 5;
  localparam int unsigned DB_CNT   = 4;
  localparam int unsigned CYC_W    = 4;

  logic clk = 1'b0;
  logic rst;

  cpu_clk_ctrl_if #(.CYC_W(CYC_W)) bus ();

  cpu_clk_ctrl #(
    .DIV_W    (26),
    .DIV_FAST (DIV_FAST),
    .DIV_SLOW (DIV_SLOW),
    .DB_CNT   (DB_CNT),
    .CYC_W    (CYC_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned ref_cnt  = 0;
  int unsigned rises    = 0;
  int unsigned run_len  = 0;
  int unsigned last_len = 0;
  logic        prev_clk = 1'b0;
  logic        changed  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: sample at the falling edge, check enable/count rules, track CPUCLK phase lengths.
  task automatic tick();
    logic rise;
    @(negedge clk);
    rise    = bus.CPUCLK & ~prev_clk;
    changed = (bus.CPUCLK !== prev_clk);
    if (rise) begin
      rises++;
      ref_cnt++;
    end
    check("cpu_ce_on_rise", 32'(bus.cpu_ce), 32'(rise));
    check("cycle_cnt", 32'(bus.cycle_cnt), ref_cnt % (1 << CYC_W));
    if (changed) begin
      last_len = run_len;
      run_len  = 1;
    end else begin
      run_len++;
    end
    prev_clk = bus.CPUCLK;
  endtask

  // Tick and, on every falling CPUCLK, require the completed high phase to be exp_hi long.
  task automatic tick_hi(input int unsigned exp_hi);
    tick();
    if (changed && !bus.CPUCLK) check("high_phase", last_len, exp_hi);
  endtask

  task automatic wait_change(input int unsigned maxc, output int unsigned waited,
                             output int unsigned len);
    int unsigned n = 0;
    do begin
      tick();
      n++;
    end while (!changed && n < maxc);
    check("edge_within_budget", 32'(changed), 32'd1);
    waited = n;
    len    = last_len;
  endtask

  task automatic wait_rise(input int unsigned maxc);
    int unsigned w, l;
    int unsigned guard = 0;
    do begin
      wait_change(maxc, w, l);
      guard++;
    end while (bus.CPUCLK !== 1'b1 && guard < 4);
    check("rise_seen", 32'(bus.CPUCLK), 32'd1);
  endtask

  task automatic do_reset(input int unsigned cycles);
    rst     = 1'b1;
    ref_cnt = 0;
    repeat (cycles) tick();
    check("rst_CPUCLK", 32'(bus.CPUCLK), 32'd0);
    check("rst_cpu_ce", 32'(bus.cpu_ce), 32'd0);
    check("rst_running", 32'(bus.running), 32'd0);
    check("rst_cycle_cnt", 32'(bus.cycle_cnt), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned w, len, r0, plen;
    rst          = 1'b1;
    bus.SW       = 1'b0;
    bus.speed    = 1'b0;
    bus.step_btn = 1'b0;
    bus.halt     = 1'b0;

    // 1: reset, then RUN at fast speed: first rise 2 clk after RUN entry, 2/2 phases
    do_reset(2);
    tick();
    check("run_entry", 32'(bus.running), 32'd1);
    wait_change(20, w, len);
    check("first_rise_latency", w, 32'd2);
    for (int i = 0; i < 4; i++) begin
      wait_change(20, w, len);
      check("fast_high", len, DIV_FAST);
      wait_change(20, w, len);
      check("fast_low", len, DIV_FAST);
    end
    check("running_in_run", 32'(bus.running), 32'd1);

    // 2: speed changes at random points mid-phase
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(0, 3)) tick();
      bus.speed = ~bus.speed;
      plen = bus.speed ? DIV_SLOW : DIV_FAST;
      wait_change(40, w, len);
      check("min_phase", 32'(len >= 2), 32'd1);
      for (int i = 0; i < int'($urandom_range(2, 4)); i++) begin
        wait_change(40, w, len);
        check("speed_phase", len, plen);
      end
    end
    bus.speed = 1'b0;
    wait_change(40, w, len);

    // 3: SW=1 in RUN: the current high phase completes, then CPUCLK stays low
    repeat ($urandom_range(0, 3)) tick();
    bus.SW = 1'b1;
    r0 = rises;
    repeat (12) tick_hi(DIV_FAST);
    check("step_entry_no_rise", rises - r0, 32'd0);
    check("step_entry_running", 32'(bus.running), 32'd0);
    check("step_entry_CPUCLK", 32'(bus.CPUCLK), 32'd0);

    // button presses: accepted iff held for at least DB_CNT clocks
    for (int k = 0; k < 8; k++) begin
      int unsigned hold;
      hold = (k == 0) ? 8 : (k == 1) ? 2 : $urandom_range(1, 8);
      r0 = rises;
      bus.step_btn = 1'b1;
      repeat (hold) tick_hi(DIV_FAST);
      bus.step_btn = 1'b0;
      repeat (16) tick_hi(DIV_FAST);
      check("press_pulses", rises - r0, 32'(hold >= DB_CNT));
      check("step_idle_CPUCLK", 32'(bus.CPUCLK), 32'd0);
    end

    // second press while the stepped cycle is still in progress is dropped
    bus.speed = 1'b1;
    r0 = rises;
    bus.step_btn = 1'b1;
    repeat (4) tick_hi(DIV_SLOW);
    bus.step_btn = 1'b0;
    repeat (4) tick_hi(DIV_SLOW);
    bus.step_btn = 1'b1;
    repeat (4) tick_hi(DIV_SLOW);
    bus.step_btn = 1'b0;
    repeat (30) tick_hi(DIV_SLOW);
    check("press_during_step", rises - r0, 32'd1);
    bus.speed = 1'b0;

    // 4: halt in RUN -> no further rise, sticky until reset
    bus.SW = 1'b0;
    repeat ($urandom_range(6, 14)) tick();
    check("rerun_running", 32'(bus.running), 32'd1);
    bus.halt = 1'b1;
    r0 = rises;
    repeat (10) tick_hi(DIV_FAST);
    check("halt_no_rise", rises - r0, 32'd0);
    check("halt_running", 32'(bus.running), 32'd0);
    check("halt_CPUCLK", 32'(bus.CPUCLK), 32'd0);
    bus.halt = 1'b0;
    bus.SW   = 1'b1;
    bus.step_btn = 1'b1;
    repeat (8) tick();
    bus.step_btn = 1'b0;
    repeat (10) tick();
    bus.SW = 1'b0;
    repeat (10) tick();
    check("halted_sticky_rises", rises - r0, 32'd0);
    check("halted_sticky_running", 32'(bus.running), 32'd0);

    // 5: reset while CPUCLK is high
    do_reset(2);
    tick();
    wait_rise(20);
    if ($urandom_range(0, 1) == 1) tick();
    check("pre_reset_high", 32'(bus.CPUCLK), 32'd1);
    rst     = 1'b1;
    ref_cnt = 0;
    tick();
    check("midrst_CPUCLK", 32'(bus.CPUCLK), 32'd0);
    check("midrst_cycle_cnt", 32'(bus.cycle_cnt), 32'd0);
    check("midrst_running", 32'(bus.running), 32'd0);
    rst = 1'b0;
    tick();
    check("post_rst_run", 32'(bus.running), 32'd1);
    wait_change(20, w, len);
    check("post_rst_first_rise", w, 32'd2);

    // 6: 16 cpu_ce pulses from reset wrap cycle_cnt
    do_reset(2);
    for (int unsigned i = 1; i <= 16; i++) begin
      wait_rise(20);
      if (i == 15) check("cnt_at_15", 32'(bus.cycle_cnt), 32'd15);
      if (i == 16) check("cnt_wrap", 32'(bus.cycle_cnt), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
